// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types for the round-robin multiplier scheduler.
// Holds the FSM encoding and the round-robin pick helper.
package mult_sched_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, RESP} sched_state_t;

    // Largest requester count the pick helper handles.
    localparam int MAX_N  = 32;
    localparam int PICK_W = 5;

    typedef struct packed {
        logic              found;
        logic [PICK_W-1:0] idx;
        logic [MAX_N-1:0]  grant;
    } rr_pick_t;

    // First set request bit after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_N-1:0]  req,
        input logic [PICK_W-1:0] ptr,
        input int                n
    );
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (k <= n && !r.found) begin
                j = (int'(ptr) + k) % n;
                if (req[j]) begin
                    r.found    = 1'b1;
                    r.idx      = PICK_W'(j);
                    r.grant[j] = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_if.sv
// Request/response bundle between clients and the scheduler.
// master = client side, slave = scheduler side.
interface mult_rr_scheduler_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]          req_valid;
    logic [N-1:0][W-1:0]   req_a;
    logic [N-1:0][W-1:0]   req_b;
    logic [N-1:0]          req_ready;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [2*W-1:0]        resp_prod;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_prod, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_prod, busy
    );

endinterface

// File: rtl/mult_rr_scheduler_slow_mult.sv
// SlowMult: serial shift-add unsigned multiplier, one bit per clock.
// start loads operands; valid pulses once when product is final.
module SlowMult #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           valid,
    output logic           busy
);
    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign product = acc;

    // Load on start, then add-and-shift for W cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start && !busy) begin
                acc    <= '0;
                mcand  <= {{W{1'b0}}, a};
                mplier <= b;
                cnt    <= CW'(W);
                busy   <= 1'b1;
            end else if (busy) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one SlowMult among N requesters.
// One operation in flight; tagged response with backpressure.
module mult_rr_scheduler
    import mult_sched_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mult_rr_scheduler_if.slave   bus
);
    localparam int ID_W = $clog2(N);

    sched_state_t    state;
    sched_state_t    state_nxt;
    rr_pick_t        pick;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            core_start;
    logic            core_valid;
    logic            core_busy;
    logic [2*W-1:0]  core_prod;
    logic            unused_bits;

    assign pick = rr_pick(MAX_N'(bus.req_valid), PICK_W'(rr_ptr), N);
    assign pick_idx = pick.idx[ID_W-1:0];
    assign unused_bits = ^{pick, core_busy};

    SlowMult #(.W(W)) core (
        .clk     (clk),
        .rst     (~rst_n),
        .start   (core_start),
        .a       (a_q),
        .b       (b_q),
        .product (core_prod),
        .valid   (core_valid),
        .busy    (core_busy)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; core valid only matters in RUN.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (pick.found) state_nxt = START;
            START: state_nxt = RUN;
            RUN:   if (core_valid) state_nxt = RESP;
            RESP:  if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; grant is combinational in IDLE.
    always_comb begin
        bus.req_ready  = '0;
        bus.resp_valid = 1'b0;
        bus.busy       = (state != IDLE);
        core_start     = 1'b0;
        unique case (state)
            IDLE:  if (pick.found) bus.req_ready = pick.grant[N-1:0];
            START: core_start = 1'b1;
            RESP:  bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand/owner capture, response hold and pointer advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= '0;
            b_q           <= '0;
            gnt_q         <= '0;
            rr_ptr        <= ID_W'(N - 1);
            bus.resp_id   <= '0;
            bus.resp_prod <= '0;
        end else begin
            if (state == IDLE && pick.found) begin
                a_q   <= bus.req_a[pick_idx];
                b_q   <= bus.req_b[pick_idx];
                gnt_q <= pick_idx;
            end
            if (state == RUN && core_valid) begin
                bus.resp_prod <= core_prod;
                bus.resp_id   <= gnt_q;
            end
            if (state == RESP && bus.resp_ready) begin
                rr_ptr <= gnt_q;
            end
        end
    end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler (N=4, W=8).
// Accepts push expected results; a negedge monitor checks responses.
module tb_mult_rr_scheduler;
    import mult_sched_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult_rr_scheduler_if #(.N(N), .W(W)) bus ();

    mult_rr_scheduler #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int id;
        int prod;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   grants[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rr_last = N - 1;
    bit   in_flight = 1'b0;
    int   accept_cnt[N];
    int   ready_cyc[N];
    int   seen[N];
    bit   prev_stall = 1'b0;
    int   prev_id;
    int   prev_prod;
    int   last_id = -1;
    int   last_prod = -1;
    logic [N-1:0] mv;
    logic [N-1:0] mr;
    int   mg;
    exp_t me;

    always @(posedge clk) cyc++;

    function automatic void chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string nm);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endfunction

    // Round-robin rule: first valid after the last served channel.
    function automatic int model_pick(logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(rr_last + k) % N]) return (rr_last + k) % N;
        end
        return -1;
    endfunction

    // Monitor: grant rule, scoreboard push on accept, response checks.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            in_flight = 1'b0;
            rr_last = N - 1;
            prev_stall = 1'b0;
        end else begin
            mv = bus.req_valid;
            mr = bus.req_ready;
            for (int c = 0; c < N; c++) if (mr[c]) ready_cyc[c]++;
            chk("busy", bus.busy, in_flight);
            chk("core_valid_outside_run",
                dut.core_valid && dut.state != RUN, 0);
            if (in_flight) begin
                chk("ready_while_busy", mr, 0);
            end else begin
                mg = model_pick(mv);
                if (mg < 0) begin
                    chk("ready_no_req", mr, 0);
                end else begin
                    chk("grant", mr, 1 << mg);
                    me.id = mg;
                    me.prod = int'(bus.req_a[mg]) * int'(bus.req_b[mg]);
                    me.acc_cyc = cyc;
                    sb.push_back(me);
                    grants.push_back(mg);
                    rr_last = mg;
                    in_flight = 1'b1;
                end
            end
            for (int c = 0; c < N; c++) begin
                if (mv[c] && mr[c]) accept_cnt[c]++;
            end
            if (bus.resp_valid) begin
                if (!prev_stall) begin
                    if (sb.size() == 0) fail_now("unexpected_resp");
                    else chk("latency", cyc - sb[0].acc_cyc, W + 3);
                end else begin
                    chk("stable_id", bus.resp_id, prev_id);
                    chk("stable_prod", bus.resp_prod, prev_prod);
                end
                if (bus.resp_ready && sb.size() > 0) begin
                    me = sb.pop_front();
                    chk("resp_id", bus.resp_id, me.id);
                    chk("resp_prod", bus.resp_prod, me.prod);
                    last_id = int'(bus.resp_id);
                    last_prod = int'(bus.resp_prod);
                    in_flight = 1'b0;
                end
            end else if (prev_stall) begin
                fail_now("resp_dropped_before_ready");
            end
            prev_stall = bus.resp_valid && !bus.resp_ready;
            prev_id = int'(bus.resp_id);
            prev_prod = int'(bus.resp_prod);
        end
    end

    function automatic int total_acc();
        int s = 0;
        for (int c = 0; c < N; c++) s += accept_cnt[c];
        return s;
    endfunction

    function automatic int rnd_op();
        case ($urandom_range(7))
            0: return 0;
            1: return 255;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    // Advance one cycle; requesters drop valid after their accept.
    task automatic step();
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (seen[c] != accept_cnt[c]) begin
                seen[c] = accept_cnt[c];
                bus.req_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic set_req(int ch, int a, int b);
        bus.req_valid[ch] = 1'b1;
        bus.req_a[ch] = W'(a);
        bus.req_b[ch] = W'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic drain(int budget);
        int k = 0;
        bus.resp_ready = 1'b1;
        while ((in_flight || sb.size() > 0) && k < budget) begin
            step();
            k++;
        end
        if (k >= budget) fail_now("drain_timeout");
    endtask

    task automatic issue(int ch, int a, int b);
        int k = 0;
        set_req(ch, a, b);
        while (bus.req_valid[ch] && k < 100) begin
            step();
            k++;
        end
        if (k >= 100) fail_now("accept_timeout");
    endtask

    task automatic run_ops(int n, int pv, int pr, int budget);
        int base = total_acc();
        int k = 0;
        while (total_acc() - base < n && k < budget) begin
            step();
            for (int c = 0; c < N; c++) begin
                if (!bus.req_valid[c] && $urandom_range(99) < pv)
                    set_req(c, rnd_op(), rnd_op());
            end
            bus.resp_ready = ($urandom_range(99) < pr);
            k++;
        end
        if (k >= budget) fail_now("random_ops_timeout");
        k = 0;
        while (bus.req_valid != '0 && k < 1000) begin
            step();
            bus.resp_ready = ($urandom_range(99) < pr);
            k++;
        end
        if (k >= 1000) fail_now("random_flush_timeout");
    endtask

    initial begin
        int r0;
        int g0;
        int k;

        // Reset state.
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = 1'b1;
        #2;
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_resp_id", bus.resp_id, 0);
        chk("rst_resp_prod", bus.resp_prod, 0);
        chk("rst_busy", bus.busy, 0);
        do_reset();

        // Single requester on ch2.
        r0 = ready_cyc[2];
        issue(2, 13, 11);
        drain(40);
        chk("t1_ready_cycles", ready_cyc[2] - r0, 1);
        chk("t1_id", last_id, 2);
        chk("t1_prod", last_prod, 143);

        // All four held from reset: grant order 0,1,2,3,0,...
        do_reset();
        g0 = grants.size();
        for (int c = 0; c < N; c++) set_req(c, rnd_op(), rnd_op());
        k = 0;
        while (total_acc() < 0 || (grants.size() - g0 < 8 && k < 300)) begin
            step();
            for (int c = 0; c < N; c++)
                if (!bus.req_valid[c]) set_req(c, rnd_op(), rnd_op());
            k++;
        end
        if (k >= 300) fail_now("t2_timeout");
        k = 0;
        while (bus.req_valid != '0 && k < 200) begin
            step();
            k++;
        end
        drain(40);
        for (int i = 0; i < 8; i++) begin
            if (g0 + i < grants.size())
                chk("t2_order", grants[g0 + i], i % N);
        end

        // Width corner cases.
        issue(0, 255, 255);
        drain(40);
        chk("t3_max", last_prod, 65025);
        issue(1, 0, 200);
        drain(40);
        chk("t3_zero", last_prod, 0);
        issue(2, 1, 255);
        drain(40);
        chk("t3_one", last_prod, 255);

        // Response backpressure with another channel waiting.
        bus.resp_ready = 1'b0;
        set_req(1, 100, 3);
        set_req(3, 45, 67);
        k = 0;
        while (!bus.resp_valid && k < 40) begin
            step();
            k++;
        end
        if (k >= 40) fail_now("t4_resp_timeout");
        repeat (6) step();
        chk("t4_held_valid", bus.resp_valid, 1);
        bus.resp_ready = 1'b1;
        k = 0;
        while (bus.req_valid != '0 && k < 60) begin
            step();
            k++;
        end
        if (k >= 60) fail_now("t4_accept_timeout");
        drain(40);

        // Reset in the middle of RUN discards the op.
        do_reset();
        issue(1, 200, 150);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        step();
        chk("t5_resp_valid", bus.resp_valid, 0);
        chk("t5_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (20) step();
        issue(3, 7, 9);
        drain(40);
        chk("t5_id", last_id, 3);
        chk("t5_prod", last_prod, 63);

        // Random traffic.
        do_reset();
        run_ops(1000, 40, 70, 60000);
        drain(200);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
